uart_rx_deser: RTL and testbench
================================

// Module: uart_rx_deser
// PURPOSE
//  Parametrised UART receive deserialiser: oversampled start detect, mid-bit sampling, 5..MAX_DATA_W data bits.
//  Checks odd/even/stick parity and the first stop bit. Detects break and overrun.
//  Sits between the line pin and the RX FIFO/RBR. Holds the received word until the consumer acks.
// PARAMETERS
//  MAX_DATA_W   8   widest data word supported; len_in selects active width
//  LEN_W        3   width of len_in; must be >= clog2(MAX_DATA_W)
//  SYNC_STG     2   serial_in synchroniser flops, minimum 2
//  OSR_HI       16  oversample ratio when osm_sel_in=0
//  OSR_LO       13  oversample ratio when osm_sel_in=1
// PORTS
//  bclk_in         in   1           oversample clock; all logic on posedge
//  rstn_in         in   1           asynchronous, active-low reset
//  enable_in       in   1           receiver enable; 0 aborts any frame in progress
//  serial_in       in   1           asynchronous line input, idle high
//  osm_sel_in      in   1           1: OSR_LO, 0: OSR_HI
//  len_in          in   LEN_W       data bits minus 1; values 4..MAX_DATA_W-1 valid
//  pen_in          in   1           parity bit present
//  eps_in          in   1           1: even parity, 0: odd
//  sp_in           in   1           stick parity; expected parity bit = !eps_in
//  ack_in          in   1           consumer has taken data_out; clears valid_out and overrun_out
//  data_out        out  MAX_DATA_W  received word, LSB = first bit; unused upper bits 0
//  valid_out       out  1           data_out and error flags valid; held until ack_in
//  parity_err_out  out  1           parity mismatch for data_out
//  frame_err_out   out  1           first stop bit sampled 0
//  break_out       out  1           data, parity and stop all 0
//  overrun_out     out  1           frame completed while valid_out=1; sticky until ack_in
//  busy_out        out  1           state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; synchroniser flops 1.
//  Definitions:
//   OSR = 16 or 13 per osm_sel_in; MID = (OSR-1)/2, i.e. 7 or 6.
//   rx_s = serial_in after SYNC_STG flops.
//  IDLE: if enable_in && rx_s==0 -> START with cnt=0. Config (osm_sel, len, pen, eps, sp) is latched here.
//   Mid-frame config changes are ignored.
//  START: cnt++; at cnt==MID sample the line. If the sample is 1, it is a false start -> IDLE. Else cnt=0 -> DATA.
//  DATA: sample when cnt==OSR-1, then cnt=0. Bits shift in LSB-first.
//   After len+1 bits -> PARITY if pen, else STOP.
//  PARITY: sample as in DATA.
//   Expected bit: sp ? !eps : (eps ? ^data : ~^data). Mismatch sets perr.
//  STOP: sample as in DATA.
//   0 -> ferr. If data==0, parity (if present)==0 and stop==0, set brk.
//   Next state: BRK_WAIT if brk, else IDLE.
//  BRK_WAIT: stay until rx_s==1, then -> IDLE. No new start is accepted while here.
//  Completion, on the cycle after the STOP sample:
//   data_out and the flags are loaded and valid_out=1.
//   If valid_out was already 1 and ack_in=0, then overrun_out=1 and the new word overwrites the old one.
//  ack_in: clears valid_out and overrun_out next cycle. ack_in in the same cycle as a completion: the completion wins, valid stays 1, no overrun.
//  Latency: valid_out rises MID + (len+2+pen)*OSR - OSR + OSR + 1 clk after the IDLE->START cycle, i.e. MID + (len+2+pen)*OSR + 1.
//  enable_in=0 in any state: -> IDLE next clk and the partial frame is discarded.
//   valid_out and data_out keep their last values.
//  len_in out of range: treated as MAX_DATA_W-1.
//  Counters are wide enough for OSR_HI-1 and never wrap within a frame.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each sample is the majority of the last 3 rx_s values at the sample cycle.
//   The start check also uses the majority.
//  Undefined: single rx_s value at the sample cycle. Timing is identical either way.
// STRUCTURE
//  uart_pkg: rx state enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT), OSR_HI/OSR_LO defaults, parity_calc function.
//  Sub-module uart_rx_sampler: synchroniser, 3-deep history/majority, and the cnt/sample_tick generator.
//  uart_rx_deser keeps the FSM, shift register and output/handshake logic.
// TESTING
//  1. OSR16, len=7, no parity, send 0xA5 with stop=1 -> valid_out rises 7+9*16+1=152 clk after START; data_out=0xA5; all error flags 0.
//  2. OSR13, len=4, pen=1, eps=1, send 0x13 with parity bit 0 -> data_out=0x13, parity_err_out=1. Repeat with parity bit 1 -> parity_err_out=0.
//  3. Line low for 5 clk then high at OSR16 -> back to IDLE at MID, busy_out drops, valid_out stays 0.
//  4. Line held low for 2 full frames at len=7, pen=1 -> break_out=1, frame_err_out=1, data_out=0. No second frame until line high.
//  5. Two frames back-to-back with no ack_in -> overrun_out=1, data_out = second word. ack_in pulse -> valid_out=0 and overrun_out=0 next clk.
//  6. enable_in=0 mid-DATA, then async reset mid-frame -> FSM in IDLE, outputs at reset values. Next clean frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: rx FSM states,
// default oversample ratios and the parity expectation function.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BRK_WAIT
    } rx_state_e;

    localparam int OSR_HI_DEF = 16;
    localparam int OSR_LO_DEF = 13;

    // Stick parity forces the bit to !eps; otherwise even/odd over the data word.
    function automatic logic parity_calc(input logic sp, input logic eps, input logic data_xor);
        if (sp)
            return !eps;
        return eps ? data_xor : !data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, optional 3-sample majority vote and bit-timing counter.
// UART_RX_MAJORITY_EN: sample value is the majority of the last three rx_s values.
module uart_rx_sampler import uart_pkg::*; #(
    parameter int SYNC_STG = 2,
    parameter int OSR_HI   = OSR_HI_DEF,
    parameter int OSR_LO   = OSR_LO_DEF
) (
    input  logic bclk_in,
    input  logic rstn_in,
    input  logic serial_in,
    input  logic run,
    input  logic mid_phase,
    input  logic osr_lo,
    output logic rx_s,
    output logic smp,
    output logic tick
);

    localparam int CNT_W = $clog2(OSR_HI);
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(OSR_HI - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(OSR_LO - 1);
    localparam logic [CNT_W-1:0] HI_MID  = CNT_W'((OSR_HI - 1) / 2);
    localparam logic [CNT_W-1:0] LO_MID  = CNT_W'((OSR_LO - 1) / 2);

    logic [SYNC_STG-1:0] sync_q;
    logic [CNT_W-1:0]    cnt, cnt_end;

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STG-2:0], serial_in};
    end

    assign rx_s = sync_q[SYNC_STG-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in)
            hist <= '1;
        else
            hist <= {hist[0], rx_s};
    end

    assign smp = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign smp = rx_s;
`endif

    // The start bit is checked at its middle; every later bit one full OSR on.
    always_comb begin
        cnt_end = osr_lo ? LO_LAST : HI_LAST;
        if (mid_phase)
            cnt_end = osr_lo ? LO_MID : HI_MID;
    end

    assign tick = run && (cnt == cnt_end);

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in)
            cnt <= '0;
        else if (!run || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: frame FSM, data shift register and held-word handshake.
// UART_RX_MAJORITY_EN (in uart_rx_sampler) selects majority-vote sampling.
module uart_rx_deser import uart_pkg::*; #(
    parameter int MAX_DATA_W = 8,
    parameter int LEN_W      = 3,
    parameter int SYNC_STG   = 2,
    parameter int OSR_HI     = OSR_HI_DEF,
    parameter int OSR_LO     = OSR_LO_DEF
) (
    input  logic                  bclk_in,
    input  logic                  rstn_in,
    input  logic                  enable_in,
    input  logic                  serial_in,
    input  logic                  osm_sel_in,
    input  logic [LEN_W-1:0]      len_in,
    input  logic                  pen_in,
    input  logic                  eps_in,
    input  logic                  sp_in,
    input  logic                  ack_in,
    output logic [MAX_DATA_W-1:0] data_out,
    output logic                  valid_out,
    output logic                  parity_err_out,
    output logic                  frame_err_out,
    output logic                  break_out,
    output logic                  overrun_out,
    output logic                  busy_out
);

    rx_state_e             state_q, state_d;
    logic                  rx_s, smp, tick, run;
    logic                  cfg_osm, cfg_pen, cfg_eps, cfg_sp;
    logic [LEN_W-1:0]      cfg_len, len_eff, bit_idx;
    logic [MAX_DATA_W-1:0] shreg;
    logic                  perr_q, par_q, brk_now, done;

    assign len_eff = (int'(len_in) < 4 || int'(len_in) > MAX_DATA_W - 1)
                   ? LEN_W'(MAX_DATA_W - 1) : len_in;
    assign run      = state_q inside {START, DATA, PARITY, STOP};
    assign busy_out = (state_q != IDLE);

    uart_rx_sampler #(
        .SYNC_STG (SYNC_STG),
        .OSR_HI   (OSR_HI),
        .OSR_LO   (OSR_LO)
    ) u_smp (
        .bclk_in   (bclk_in),
        .rstn_in   (rstn_in),
        .serial_in (serial_in),
        .run       (run),
        .mid_phase (state_q == START),
        .osr_lo    (cfg_osm),
        .rx_s      (rx_s),
        .smp       (smp),
        .tick      (tick)
    );

    assign brk_now = (shreg == '0) && !(cfg_pen && par_q) && !smp;
    assign done    = enable_in && (state_q == STOP) && tick;

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!rx_s) state_d = START;
            START:    if (tick) state_d = smp ? IDLE : DATA;
            DATA:     if (tick && bit_idx == cfg_len) state_d = cfg_pen ? PARITY : STOP;
            PARITY:   if (tick) state_d = STOP;
            STOP:     if (tick) state_d = brk_now ? BRK_WAIT : IDLE;
            BRK_WAIT: if (rx_s) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (!enable_in)
            state_d = IDLE;
    end

    // Config is captured continuously while idle, frozen for the whole frame.
    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            cfg_osm <= 1'b0;
            cfg_len <= '0;
            cfg_pen <= 1'b0;
            cfg_eps <= 1'b0;
            cfg_sp  <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            perr_q  <= 1'b0;
            par_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            cfg_osm <= osm_sel_in;
            cfg_len <= len_eff;
            cfg_pen <= pen_in;
            cfg_eps <= eps_in;
            cfg_sp  <= sp_in;
            shreg   <= '0;
            bit_idx <= '0;
            perr_q  <= 1'b0;
            par_q   <= 1'b0;
        end else if (tick) begin
            if (state_q == DATA) begin
                shreg[bit_idx] <= smp;
                bit_idx        <= bit_idx + 1'b1;
            end
            if (state_q == PARITY) begin
                par_q  <= smp;
                perr_q <= (smp != parity_calc(cfg_sp, cfg_eps, ^shreg));
            end
        end
    end

    // A completion beats a simultaneous ack; overrun only if the old word was never taken.
    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            data_out       <= '0;
            valid_out      <= 1'b0;
            parity_err_out <= 1'b0;
            frame_err_out  <= 1'b0;
            break_out      <= 1'b0;
            overrun_out    <= 1'b0;
        end else if (done) begin
            data_out       <= shreg;
            valid_out      <= 1'b1;
            parity_err_out <= perr_q;
            frame_err_out  <= !smp;
            break_out      <= brk_now;
            overrun_out    <= valid_out && !ack_in;
        end else if (ack_in) begin
            valid_out      <= 1'b0;
            overrun_out    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed self-checking bench for uart_rx_deser (default parameters).
module tb_uart_rx_deser;

    logic       bclk_in = 1'b0;
    logic       rstn_in, enable_in, serial_in, osm_sel_in, pen_in, eps_in, sp_in, ack_in;
    logic [2:0] len_in;
    logic [7:0] data_out;
    logic       valid_out, parity_err_out, frame_err_out, break_out, overrun_out, busy_out;

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, t_start = 0, t_valid = 0, ts0;
    logic busy_d = 1'b0, valid_d = 1'b0;

    always #5 bclk_in = ~bclk_in;

    uart_rx_deser dut (
        .bclk_in        (bclk_in),
        .rstn_in        (rstn_in),
        .enable_in      (enable_in),
        .serial_in      (serial_in),
        .osm_sel_in     (osm_sel_in),
        .len_in         (len_in),
        .pen_in         (pen_in),
        .eps_in         (eps_in),
        .sp_in          (sp_in),
        .ack_in         (ack_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .parity_err_out (parity_err_out),
        .frame_err_out  (frame_err_out),
        .break_out      (break_out),
        .overrun_out    (overrun_out),
        .busy_out       (busy_out)
    );

    // Edge timestamps of busy_out and valid_out rises, for the latency check.
    always @(posedge bclk_in) begin
        cyc++;
        #1;
        if (busy_out && !busy_d)   t_start = cyc;
        if (valid_out && !valid_d) t_valid = cyc;
        busy_d  = busy_out;
        valid_d = valid_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pb, input logic stop, input int osr);
        serial_in = 1'b0;
        repeat (osr) @(negedge bclk_in);
        for (int i = 0; i < nb; i++) begin
            serial_in = d[i];
            repeat (osr) @(negedge bclk_in);
        end
        if (pen) begin
            serial_in = pb;
            repeat (osr) @(negedge bclk_in);
        end
        serial_in = stop;
        repeat (osr) @(negedge bclk_in);
        serial_in = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        while (valid_out !== 1'b1 && n < max_cyc) begin
            @(negedge bclk_in);
            n++;
        end
        check(tag, valid_out, 1);
    endtask

    task automatic do_ack(input string tag);
        ack_in = 1'b1;
        @(posedge bclk_in);
        #1;
        check({tag, "_valid_clr"}, valid_out, 0);
        check({tag, "_ovr_clr"}, overrun_out, 0);
        @(negedge bclk_in);
        ack_in = 1'b0;
    endtask

    initial begin
        rstn_in = 1'b0; enable_in = 1'b1; serial_in = 1'b1; ack_in = 1'b0;
        osm_sel_in = 1'b0; len_in = 3'd7; pen_in = 1'b0; eps_in = 1'b0; sp_in = 1'b0;
        repeat (3) @(negedge bclk_in);
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 0);
        check("rst_perr", parity_err_out, 0);
        check("rst_ferr", frame_err_out, 0);
        check("rst_brk", break_out, 0);
        check("rst_ovr", overrun_out, 0);
        check("rst_busy", busy_out, 0);
        rstn_in = 1'b1;
        repeat (3) @(negedge bclk_in);

        // 1: OSR16, 8N1, 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16);
        wait_valid("t1_valid", 200);
        check("t1_data", data_out, 8'hA5);
        check("t1_perr", parity_err_out, 0);
        check("t1_ferr", frame_err_out, 0);
        check("t1_brk", break_out, 0);
        check("t1_ovr", overrun_out, 0);
        check("t1_latency", t_valid - t_start, 152);
        do_ack("t1");

        // 2: OSR13, 5 bits, even parity, 0x13 with wrong then right parity
        osm_sel_in = 1'b1; len_in = 3'd4; pen_in = 1'b1; eps_in = 1'b1;
        @(negedge bclk_in);
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 13);
        wait_valid("t2a_valid", 100);
        check("t2a_data", data_out, 8'h13);
        check("t2a_perr", parity_err_out, 1);
        do_ack("t2a");
        send_frame(8'h13, 5, 1'b1, 1'b1, 1'b1, 13);
        wait_valid("t2b_valid", 100);
        check("t2b_data", data_out, 8'h13);
        check("t2b_perr", parity_err_out, 0);
        check("t2b_ferr", frame_err_out, 0);
        do_ack("t2b");

        // 3: 5-clock glitch is a false start
        osm_sel_in = 1'b0; len_in = 3'd7; pen_in = 1'b0;
        @(negedge bclk_in);
        ts0 = t_start;
        serial_in = 1'b0;
        repeat (5) @(negedge bclk_in);
        serial_in = 1'b1;
        repeat (20) @(negedge bclk_in);
        check("t3_busy_seen", t_start > ts0, 1);
        check("t3_busy", busy_out, 0);
        check("t3_valid", valid_out, 0);

        // 4: line low for two full 8E1 frames -> one break, then wait for high
        pen_in = 1'b1; eps_in = 1'b1;
        @(negedge bclk_in);
        serial_in = 1'b0;
        repeat (22 * 16) @(negedge bclk_in);
        check("t4_valid", valid_out, 1);
        check("t4_brk", break_out, 1);
        check("t4_ferr", frame_err_out, 1);
        check("t4_data", data_out, 0);
        check("t4_perr", parity_err_out, 0);
        check("t4_ovr", overrun_out, 0);
        check("t4_busy_brkwait", busy_out, 1);
        serial_in = 1'b1;
        repeat (6) @(negedge bclk_in);
        check("t4_idle", busy_out, 0);
        do_ack("t4");

        // 5: back-to-back frames without ack -> overrun
        pen_in = 1'b0; eps_in = 1'b0;
        @(negedge bclk_in);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 16);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 16);
        repeat (4) @(negedge bclk_in);
        check("t5_valid", valid_out, 1);
        check("t5_ovr", overrun_out, 1);
        check("t5_data", data_out, 8'hC3);
        check("t5_brk", break_out, 0);
        do_ack("t5");

        // 6: disable mid-frame, then async reset mid-frame, then a clean frame
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
        repeat (4) @(negedge bclk_in);
        fork
            send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                repeat (60) @(negedge bclk_in);
                enable_in = 1'b0;
                @(negedge bclk_in);
                check("t6_dis_busy", busy_out, 0);
                check("t6_dis_valid", valid_out, 1);
                check("t6_dis_data", data_out, 8'h5A);
            end
        join
        enable_in = 1'b1;
        repeat (4) @(negedge bclk_in);
        fork
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                repeat (50) @(negedge bclk_in);
                #2 rstn_in = 1'b0;
                #1;
                check("t6_rst_busy", busy_out, 0);
                check("t6_rst_valid", valid_out, 0);
                check("t6_rst_data", data_out, 0);
                check("t6_rst_flags", {parity_err_out, frame_err_out, break_out, overrun_out}, 0);
            end
        join
        @(negedge bclk_in);
        rstn_in = 1'b1;
        repeat (3) @(negedge bclk_in);
        send_frame(8'h69, 8, 1'b0, 1'b0, 1'b1, 16);
        wait_valid("t6_valid", 200);
        check("t6_data", data_out, 8'h69);
        check("t6_ferr", frame_err_out, 0);
        check("t6_ovr", overrun_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
